// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: write-side controller for a 2-way x 8-set BTB.
// Resolved-branch updates are queued in a small FIFO, then each one goes
// through LOOKUP (read the set, pick a way) and WRITE (one-cycle array write
// plus LRU touch).
// Optional feature macro: BTB_UPD_STATS_EN adds the upd_hit_cnt and
// upd_evict_cnt statistics outputs.
//
// Handshake: an update transfers on a rising clk edge where upd_valid and
// upd_ready are both 1; upd_ready depends only on FIFO fullness and flush,
// never on upd_valid, and the offered fields must stay stable while
// upd_valid is held without upd_ready.
module btb_update_ctrl #(
  parameter int TAG_W      = 27,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [31:0]      upd_pc,
  input  logic [31:0]      upd_target,
  output logic [2:0]       rd_index,
  input  logic [1:0]       rd_valid,
  input  logic [TAG_W-1:0] rd_tag0,
  input  logic [TAG_W-1:0] rd_tag1,
  input  logic [7:0]       lru_in,
  output logic             wr_en,
  output logic             wr_way,
  output logic [2:0]       wr_index,
  output logic [TAG_W-1:0] wr_tag,
  output logic [31:0]      wr_target,
  output logic             lru_wr_en,
  output logic [2:0]       lru_wr_index,
`ifdef BTB_UPD_STATS_EN
  output logic [15:0]      upd_hit_cnt,
  output logic [15:0]      upd_evict_cnt,
`endif
  output logic             busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WRITE} state_t;

  // state is the FSM state; probe it by hierarchical name when debugging.
  state_t state, state_next;

  logic [2:0]       fifo_index  [FIFO_DEPTH];
  logic [TAG_W-1:0] fifo_tag    [FIFO_DEPTH];
  logic [31:0]      fifo_target [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_next;

  logic             full, push, pop;
  logic [2:0]       head_index;
  logic [TAG_W-1:0] head_tag;
  logic [31:0]      head_target;
  logic             hit0, hit1, sel_way, sel_hit, sel_evict;
  logic             reg_hit, reg_evict;
  logic             unused_pc;

  // Bits 1:0 of the PC never reach the BTB (and upper bits when TAG_W < 27).
  assign unused_pc = ^upd_pc;

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign upd_ready = !full && !flush;
  assign push      = upd_valid && upd_ready;
  assign pop       = (state == S_WRITE) && !flush;

  assign head_index  = fifo_index[rd_ptr];
  assign head_tag    = fifo_tag[rd_ptr];
  assign head_target = fifo_target[rd_ptr];
  assign rd_index    = head_index;

  assign wr_en        = (state == S_WRITE) && !flush;
  assign lru_wr_en    = wr_en;
  assign lru_wr_index = wr_index;
  assign busy         = (count != '0) || (state != S_IDLE);

  // FIFO occupancy after this cycle's push/pop/flush.
  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count + CNT_W'(1);
    end else if (!push && pop) begin
      count_next = count - CNT_W'(1);
    end
  end

  // FIFO storage and pointers; flush only rewinds pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_index[i]  <= '0;
        fifo_tag[i]    <= '0;
        fifo_target[i] <= '0;
      end
    end else begin
      count <= count_next;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          fifo_index[wr_ptr]  <= upd_pc[4:2];
          fifo_tag[wr_ptr]    <= upd_pc[5+TAG_W-1:5];
          fifo_target[wr_ptr] <= upd_target;
          wr_ptr              <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
      end
    end
  end

  // Way choice for the head entry: hit, then first invalid way, then LRU victim.
  always_comb begin
    hit0      = rd_valid[0] && (rd_tag0 == head_tag);
    hit1      = rd_valid[1] && (rd_tag1 == head_tag);
    sel_way   = 1'b0;
    sel_hit   = 1'b0;
    sel_evict = 1'b0;
    if (hit0) begin
      sel_hit = 1'b1;
    end else if (hit1) begin
      sel_way = 1'b1;
      sel_hit = 1'b1;
    end else if (!rd_valid[0]) begin
      sel_way = 1'b0;
    end else if (!rd_valid[1]) begin
      sel_way = 1'b1;
    end else begin
      sel_way   = lru_in[head_index];
      sel_evict = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state; an update pushed while idle is looked up the next cycle.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (count_next != '0) state_next = S_LOOKUP;
      S_LOOKUP: state_next = S_WRITE;
      S_WRITE:  state_next = (count_next != '0) ? S_LOOKUP : S_IDLE;
      default:  state_next = S_IDLE;
    endcase
    if (flush) begin
      state_next = S_IDLE;
    end
  end

  // Capture the write command at the end of LOOKUP; held until the next LOOKUP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_way    <= 1'b0;
      wr_index  <= '0;
      wr_tag    <= '0;
      wr_target <= '0;
      reg_hit   <= 1'b0;
      reg_evict <= 1'b0;
    end else if ((state == S_LOOKUP) && !flush) begin
      wr_way    <= sel_way;
      wr_index  <= head_index;
      wr_tag    <= head_tag;
      wr_target <= head_target;
      reg_hit   <= sel_hit;
      reg_evict <= sel_evict;
    end
  end

`ifdef BTB_UPD_STATS_EN
  // Saturating hit/eviction counters, advanced only by completed writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_hit_cnt   <= '0;
      upd_evict_cnt <= '0;
    end else if (wr_en) begin
      if (reg_hit && (upd_hit_cnt != 16'hFFFF)) begin
        upd_hit_cnt <= upd_hit_cnt + 16'd1;
      end
      if (reg_evict && (upd_evict_cnt != 16'hFFFF)) begin
        upd_evict_cnt <= upd_evict_cnt + 16'd1;
      end
    end
  end
`else
  logic unused_stats;
  assign unused_stats = reg_hit ^ reg_evict;
`endif

endmodule
